// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among
// four byte requesters, with a tx_busy handshake timeout.
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 1024,
  parameter int NUM_REQ      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic                 tx_busy,
  output logic                 tx_send,
  output logic [7:0]           tx_din,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(BUSY_TIMEOUT);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    DONE
  } state_t;

  state_t               r_state;
  logic                 r_send;
  logic [7:0]           r_din;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_busy;
  logic                 r_to;
  logic [IW-1:0]        r_last;
  logic [IW-1:0]        r_gidx;
  logic [CW-1:0]        r_cnt;

  state_t               w_state_n;
  logic                 w_send_n;
  logic [7:0]           w_din_n;
  logic [NUM_REQ-1:0]   w_grant_n;
  logic [NUM_REQ-1:0]   w_ack_n;
  logic                 w_busy_n;
  logic                 w_to_n;
  logic [IW-1:0]        w_last_n;
  logic [IW-1:0]        w_gidx_n;
  logic [CW-1:0]        w_cnt_n;
  logic [CW-1:0]        w_cnt_inc;

  logic                 w_found;
  logic [IW-1:0]        w_win;
  logic [IW-1:0]        w_idx;

  // Search starts just after the last winner, so it has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = r_last + IW'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_n = r_state;
    w_send_n  = r_send;
    w_din_n   = r_din;
    w_grant_n = r_grant;
    w_ack_n   = '0;
    w_busy_n  = r_busy;
    w_to_n    = 1'b0;
    w_last_n  = r_last;
    w_gidx_n  = r_gidx;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_n = NUM_REQ'(1) << w_win;
          w_din_n   = req_data[{w_win, 3'b000} +: 8];
          w_gidx_n  = w_win;
          w_send_n  = 1'b1;
          w_busy_n  = 1'b1;
          w_cnt_n   = '0;
          w_state_n = SEND;
        end
      end
      SEND: begin
        if (tx_busy) begin
          w_send_n  = 1'b0;
          w_state_n = WAIT_DONE;
        end else if (w_cnt_inc == TO_LIM) begin
          // Give up on this transfer; pointer still moves past it.
          w_send_n  = 1'b0;
          w_grant_n = '0;
          w_busy_n  = 1'b0;
          w_to_n    = 1'b1;
          w_last_n  = r_gidx;
          w_cnt_n   = '0;
          w_state_n = IDLE;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_ack_n   = r_grant;
          w_state_n = DONE;
        end
      end
      DONE: begin
        w_grant_n = '0;
        w_busy_n  = 1'b0;
        w_last_n  = r_gidx;
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_send  <= 1'b0;
      r_din   <= 8'h00;
      r_grant <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_to    <= 1'b0;
      r_last  <= LAST_RST;
      r_gidx  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_send  <= w_send_n;
      r_din   <= w_din_n;
      r_grant <= w_grant_n;
      r_ack   <= w_ack_n;
      r_busy  <= w_busy_n;
      r_to    <= w_to_n;
      r_last  <= w_last_n;
      r_gidx  <= w_gidx_n;
      r_cnt   <= w_cnt_n;
    end
  end

  assign tx_send     = r_send;
  assign tx_din      = r_din;
  assign grant       = r_grant;
  assign ack         = r_ack;
  assign busy        = r_busy;
  assign timeout_err = r_to;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with an event scoreboard
// for the shared-UART round-robin arbiter.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_send;
  logic [7:0]  tx_din;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .BUSY_TIMEOUT(TO),
    .NUM_REQ(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .tx_busy(tx_busy),
    .tx_send(tx_send),
    .tx_din(tx_din),
    .grant(grant),
    .ack(ack),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  typedef enum int {K_SEND, K_ACK, K_TO} kind_t;
  typedef struct {
    kind_t      k;
    logic [3:0] g;
    logic [7:0] d;
  } ev_t;

  ev_t  exq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_len = 100;
  bit   uart_en = 1'b1;
  logic m_ps = 1'b0;
  logic [3:0] m_pa = '0;

  task automatic push(kind_t k, logic [3:0] g, logic [7:0] d);
    ev_t e;
    e.k = k;
    e.g = g;
    e.d = d;
    exq.push_back(e);
  endtask

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mon_pop(kind_t k, logic [3:0] g, logic [7:0] d,
                         string nm);
    ev_t e;
    n_vec++;
    if (exq.size() == 0) begin
      n_err++;
      $display("FAIL %s unexpected: vec=%b din=%h, required none",
               nm, g, d);
    end else begin
      e = exq.pop_front();
      if (e.k != k || e.g !== g || (k == K_SEND && e.d !== d)) begin
        n_err++;
        $display("FAIL %s: got kind=%0d vec=%b din=%h, required kind=%0d vec=%b din=%h",
                 nm, k, g, d, e.k, e.g, e.d);
      end
    end
  endtask

  // Monitor: every start, ack or timeout pulse is matched to the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_send && !m_ps)
        mon_pop(K_SEND, grant, tx_din, "send");
      if (ack != 4'b0) begin
        mon_pop(K_ACK, ack, 8'h00, "ack");
        check("ack_width", 32'(m_pa), 32'h0);
        check("ack_in_grant", 32'(ack & ~grant), 32'h0);
      end
      if (timeout_err)
        mon_pop(K_TO, grant, 8'h00, "timeout");
      m_ps = tx_send;
      m_pa = ack;
    end
  end

  // UART model: busy rises 2 cycles after tx_send, lasts busy_len.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_en && tx_send && !rst) begin
        repeat (2) @(negedge clk);
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_busy(logic lvl, string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (tx_busy !== lvl && n < 400);
    check(nm, 32'(tx_busy), 32'(lvl));
  endtask

  task automatic wait_drain(string nm);
    int n;
    n = 0;
    while (exq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(exq.size()), 32'h0);
  endtask

  task automatic check_idle(string nm);
    check({nm, "_send"}, 32'(tx_send), 32'h0);
    check({nm, "_din"}, 32'(tx_din), 32'h0);
    check({nm, "_grant"}, 32'(grant), 32'h0);
    check({nm, "_ack"}, 32'(ack), 32'h0);
    check({nm, "_busy"}, 32'(busy), 32'h0);
    check({nm, "_to"}, 32'(timeout_err), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bit bad;

    // Reset held with requests pending: nothing may be granted.
    req = 4'b1111;
    repeat (4) @(negedge clk);
    check_idle("rst");
    req = 4'b0000;
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 0.
    req_data = 32'h0000_00A5;
    push(K_SEND, 4'b0001, 8'hA5);
    push(K_ACK, 4'b0001, 8'h00);
    req = 4'b0001;
    @(negedge clk);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_din", 32'(tx_din), 32'hA5);
    check("t1_send", 32'(tx_send), 32'h1);
    wait_busy(1'b1, "t1_busy_rise");
    @(negedge clk);
    check("t1_send_drop", 32'(tx_send), 32'h0);
    n = 0;
    while (ack == 4'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t1_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    check("t1_ack_clear", 32'(ack), 32'h0);
    check("t1_busy_low", 32'(busy), 32'h0);
    check("t1_grant_low", 32'(grant), 32'h0);
    wait_drain("t1_drain");

    // Fairness with all four requesting from a fresh pointer.
    busy_len = 10;
    do_reset();
    req_data = 32'h4433_2211;
    for (int r = 0; r < 2; r++) begin
      push(K_SEND, 4'b0001, 8'h11);
      push(K_ACK,  4'b0001, 8'h00);
      push(K_SEND, 4'b0010, 8'h22);
      push(K_ACK,  4'b0010, 8'h00);
      push(K_SEND, 4'b0100, 8'h33);
      push(K_ACK,  4'b0100, 8'h00);
      push(K_SEND, 4'b1000, 8'h44);
      push(K_ACK,  4'b1000, 8'h00);
    end
    req = 4'b1111;
    wait_drain("t2_drain");
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Busy never rises: timeout after TO send cycles.
    uart_en = 1'b0;
    req_data = 32'h0077_0099;
    push(K_SEND, 4'b0100, 8'h77);
    push(K_TO,   4'b0000, 8'h00);
    req = 4'b0100;
    @(negedge clk);
    check("t3_send", 32'(tx_send), 32'h1);
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t3_latency", 32'(n), 32'(TO));
    check("t3_grant", 32'(grant), 32'h0);
    check("t3_busy", 32'(busy), 32'h0);
    check("t3_send_low", 32'(tx_send), 32'h0);
    check("t3_no_ack", 32'(ack), 32'h0);
    req = 4'b0101;
    uart_en = 1'b1;
    push(K_SEND, 4'b0001, 8'h99);
    push(K_ACK,  4'b0001, 8'h00);
    push(K_SEND, 4'b0100, 8'h77);
    push(K_ACK,  4'b0100, 8'h00);
    @(negedge clk);
    check("t3_to_pulse", 32'(timeout_err), 32'h0);
    wait_drain("t3_drain");
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Byte captured at grant; later req_data changes are ignored.
    req_data = 32'h0000_3C00;
    push(K_SEND, 4'b0010, 8'h3C);
    push(K_ACK,  4'b0010, 8'h00);
    req = 4'b0010;
    wait_busy(1'b1, "t4_busy_rise");
    @(negedge clk);
    req_data = 32'h0000_FF00;
    bad = 1'b0;
    n = 0;
    while (ack == 4'b0 && n < 300) begin
      if (tx_din !== 8'h3C) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    req = 4'b0000;
    check("t4_din_stable", 32'(bad), 32'h0);
    check("t4_din_at_ack", 32'(tx_din), 32'h3C);
    wait_drain("t4_drain");
    repeat (3) @(negedge clk);

    // Requester drops req while waiting for completion.
    req_data = 32'h0000_5A00;
    push(K_SEND, 4'b0010, 8'h5A);
    push(K_ACK,  4'b0010, 8'h00);
    req = 4'b0010;
    wait_busy(1'b1, "t5_busy_rise");
    @(negedge clk);
    @(negedge clk);
    req = 4'b0000;
    wait_drain("t5_drain");
    repeat (3) @(negedge clk);

    // Reset in WAIT_DONE, then a normal grant afterwards.
    req_data = 32'hC300_0000;
    push(K_SEND, 4'b1000, 8'hC3);
    req = 4'b1000;
    wait_busy(1'b1, "t6_busy_rise");
    repeat (3) @(negedge clk);
    req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    check_idle("t6_rst");
    rst = 1'b0;
    wait_busy(1'b0, "t6_busy_fall");
    repeat (3) @(negedge clk);
    check("t6_no_ack", 32'(ack), 32'h0);
    wait_drain("t6_drain_a");
    req_data = 32'h8100_0000;
    push(K_SEND, 4'b1000, 8'h81);
    push(K_ACK,  4'b1000, 8'h00);
    req = 4'b1000;
    wait_drain("t6_drain_b");
    req = 4'b0000;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
